// File: rtl/wash_seq_ctrl.sv
// Wash sequencer: N agitation cycles of CW -> P1 -> CCW -> P2 with tick-based phase
// timing, hold/resume, abort and a one-clock done pulse on normal completion.
module wash_seq_ctrl #(
  parameter int         WIDTH  = 5,
  parameter int         CYC_W  = 4,
  parameter logic [1:0] M_STOP = 2'd0,
  parameter logic [1:0] M_CW   = 2'd1,
  parameter logic [1:0] M_CCW  = 2'd2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             start,
  input  logic             hold,
  input  logic             abort,
  input  logic [CYC_W-1:0] cfg_cycles,
  input  logic [WIDTH-1:0] cfg_cw,
  input  logic [WIDTH-1:0] cfg_ccw,
  input  logic [WIDTH-1:0] cfg_pause,
  output logic [1:0]       motor,
  output logic             busy,
  output logic             done,
  output logic [2:0]       phase,
  output logic [CYC_W-1:0] cycles_left
);

  // State encoding doubles as the phase output code.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CW   = 3'd1,
    S_P1   = 3'd2,
    S_CCW  = 3'd3,
    S_P2   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] timer_q, timer_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [WIDTH-1:0] cw_q, cw_d, ccw_q, ccw_d, pause_q, pause_d;
  logic [1:0]       motor_q, motor_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] len;
  logic             phase_end;
  logic             hold_stop;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    cyc_d     = cyc_q;
    cw_d      = cw_q;
    ccw_d     = ccw_q;
    pause_d   = pause_q;
    done_d    = 1'b0;
    hold_stop = 1'b0;

    case (state_q)
      S_P1, S_P2: len = pause_q;
      S_CCW:      len = ccw_q;
      default:    len = cw_q;
    endcase
    // A zero length behaves as a one-tick phase.
    phase_end = (len == '0) ? 1'b1 : (timer_q == len - WIDTH'(1));

    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      timer_d = '0;
      cyc_d   = '0;
    end else if (state_q == S_IDLE) begin
      if (start) begin
        cw_d    = cfg_cw;
        ccw_d   = cfg_ccw;
        pause_d = cfg_pause;
        timer_d = '0;
        if (cfg_cycles != '0) begin
          state_d = S_CW;
          cyc_d   = cfg_cycles;
        end else begin
          done_d = 1'b1;
        end
      end
    end else if (hold) begin
      hold_stop = 1'b1;
    end else if (tick) begin
      if (phase_end) begin
        timer_d = '0;
        case (state_q)
          S_CW:  state_d = S_P1;
          S_P1:  state_d = S_CCW;
          S_CCW: state_d = S_P2;
          default: begin
            if (cyc_q > CYC_W'(1)) begin
              cyc_d   = cyc_q - CYC_W'(1);
              state_d = S_CW;
            end else begin
              cyc_d   = '0;
              state_d = S_IDLE;
              done_d  = 1'b1;
            end
          end
        endcase
      end else begin
        timer_d = timer_q + WIDTH'(1);
      end
    end

    case (state_d)
      S_CW:    motor_d = M_CW;
      S_CCW:   motor_d = M_CCW;
      default: motor_d = M_STOP;
    endcase
    if (hold_stop) motor_d = M_STOP;
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      cyc_q   <= '0;
      motor_q <= M_STOP;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      cyc_q   <= cyc_d;
      motor_q <= motor_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Latched phase lengths are only read outside IDLE, so they need no reset.
  always_ff @(posedge clk) begin
    cw_q    <= cw_d;
    ccw_q   <= ccw_d;
    pause_q <= pause_d;
  end

  assign motor       = motor_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign phase       = state_q;
  assign cycles_left = cyc_q;

endmodule
